// File: rtl/argmax_classifier.sv
// rtl/argmax_classifier.sv - streaming argmax over per-frame class scores; ARGMAX_SCORE_EN adds score_out
module argmax_classifier #(
    parameter int  VECTOR_LENGTH = 10,
    parameter int  NUM_FEATURES  = 2,
    parameter int  FEATURE_WIDTH = 16,
    localparam int IDX_W         = $clog2(VECTOR_LENGTH),
    localparam int BEATS         = (VECTOR_LENGTH + NUM_FEATURES - 1) / NUM_FEATURES,
    localparam int BEAT_W        = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic                                    clock,
    input  logic                                    reset_n,
    input  logic                                    features_in_valid,
    output logic                                    features_in_ready,
    input  logic [NUM_FEATURES*FEATURE_WIDTH-1:0]   features_in_data,
    output logic [IDX_W-1:0]                        class_out,
    output logic                                    class_valid,
    input  logic                                    class_ready,
    output logic [15:0]                             frame_count
`ifdef ARGMAX_SCORE_EN
    ,
    output logic [FEATURE_WIDTH-1:0]                score_out
`endif
);

    typedef enum logic {S_RECV, S_RESULT} state_t;

    state_t                    state;
    state_t                    next_state;
    logic [BEAT_W-1:0]         beat_cnt;
    logic signed [FEATURE_WIDTH-1:0] run_max;
    logic signed [FEATURE_WIDTH-1:0] beat_max;
    logic signed [FEATURE_WIDTH-1:0] win_max;
    logic [IDX_W-1:0]          run_idx;
    logic [IDX_W-1:0]          beat_idx;
    logic [IDX_W-1:0]          win_idx;
    logic [15:0]               frame_count_q;
    int                        beat_base;
    logic                      accept;
    logic                      consume;
    logic                      last_beat;

    assign accept      = features_in_valid & features_in_ready;
    assign consume     = class_valid & class_ready;
    assign last_beat   = (beat_cnt == BEAT_W'(BEATS - 1));
    assign frame_count = frame_count_q;

    // Beat reduction: lane 0 always carries a real index; later lanes past the vector end are padding
    always_comb begin
        beat_base = int'(beat_cnt) * NUM_FEATURES;
        beat_max  = features_in_data[FEATURE_WIDTH-1:0];
        beat_idx  = IDX_W'(beat_base);
        for (int i = 1; i < NUM_FEATURES; i++) begin
            if (((beat_base + i) < VECTOR_LENGTH) &&
                ($signed(features_in_data[i*FEATURE_WIDTH +: FEATURE_WIDTH]) > beat_max)) begin
                beat_max = features_in_data[i*FEATURE_WIDTH +: FEATURE_WIDTH];
                beat_idx = IDX_W'(beat_base + i);
            end
        end
    end

    // Merge beat winner into the running winner; first beat loads, later beats replace only if strictly greater
    always_comb begin
        win_max = run_max;
        win_idx = run_idx;
        if ((beat_cnt == '0) || (beat_max > run_max)) begin
            win_max = beat_max;
            win_idx = beat_idx;
        end
    end

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_RECV;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        next_state        = state;
        features_in_ready = 1'b0;
        class_valid       = 1'b0;
        case (state)
            S_RECV: begin
                features_in_ready = 1'b1;
                if (accept && last_beat) begin
                    next_state = S_RESULT;
                end
            end
            S_RESULT: begin
                class_valid = 1'b1;
                if (class_ready) begin
                    next_state = S_RECV;
                end
            end
            default: next_state = S_RECV;
        endcase
    end

    // Running max, beat counter, result and frame counter
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            beat_cnt      <= '0;
            run_max       <= '0;
            run_idx       <= '0;
            class_out     <= '0;
            frame_count_q <= 16'd0;
        end else begin
            if (accept) begin
                run_max <= win_max;
                run_idx <= win_idx;
                if (last_beat) begin
                    beat_cnt  <= '0;
                    class_out <= win_idx;
                end else begin
                    beat_cnt <= beat_cnt + BEAT_W'(1);
                end
            end
            if (consume) begin
                beat_cnt      <= '0;
                frame_count_q <= frame_count_q + 16'd1;
            end
        end
    end

`ifdef ARGMAX_SCORE_EN
    // Winning score captured together with class_out
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            score_out <= '0;
        end else if (accept && last_beat) begin
            score_out <= win_max;
        end
    end
`endif

endmodule

// File: tb/tb_argmax_classifier.sv
// tb/tb_argmax_classifier.sv - scoreboard bench for argmax_classifier (NUM_FEATURES 2 and 4)
module tb_argmax_classifier;

    typedef struct {
        int idx;
        int score;
    } res_t;

    logic        clock;
    logic        reset_n;
    logic        valid2, ready2, cvalid2, cready2;
    logic [31:0] data2;
    logic [3:0]  class2;
    logic [15:0] fc2;
    logic        valid4, ready4, cvalid4, cready4;
    logic [63:0] data4;
    logic [3:0]  class4;
    logic [15:0] fc4;
`ifdef ARGMAX_SCORE_EN
    logic [15:0] score2, score4;
`endif

    int          checks = 0;
    int          errors = 0;
    int          sc [10];
    res_t        q2 [$];
    res_t        q4 [$];
    res_t        mr2, mr4;
    logic [15:0] exp_fc2 = 16'd0;
    logic [3:0]  e_idx2, e_idx4;
    logic [15:0] e_sc2, e_sc4;

    argmax_classifier #(.VECTOR_LENGTH(10), .NUM_FEATURES(2), .FEATURE_WIDTH(16)) dut (
        .clock(clock), .reset_n(reset_n),
        .features_in_valid(valid2), .features_in_ready(ready2), .features_in_data(data2),
        .class_out(class2), .class_valid(cvalid2), .class_ready(cready2), .frame_count(fc2)
`ifdef ARGMAX_SCORE_EN
        , .score_out(score2)
`endif
    );

    argmax_classifier #(.VECTOR_LENGTH(10), .NUM_FEATURES(4), .FEATURE_WIDTH(16)) dut4 (
        .clock(clock), .reset_n(reset_n),
        .features_in_valid(valid4), .features_in_ready(ready4), .features_in_data(data4),
        .class_out(class4), .class_valid(cvalid4), .class_ready(cready4), .frame_count(fc4)
`ifdef ARGMAX_SCORE_EN
        , .score_out(score4)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Result monitor for the two-lane instance
    always @(negedge clock) begin
        if (reset_n && cvalid2 && cready2) begin
            checks++;
            if (q2.size() == 0) begin
                errors++;
                $display("FAIL unexpected_result2 class_out=%0d expected none", class2);
            end else begin
                mr2 = q2.pop_front();
                e_idx2 = mr2.idx[3:0];
                e_sc2  = mr2.score[15:0];
                if (class2 !== e_idx2) begin
                    errors++;
                    $display("FAIL class_out2 got %0d expected %0d", class2, e_idx2);
                end
`ifdef ARGMAX_SCORE_EN
                checks++;
                if (score2 !== e_sc2) begin
                    errors++;
                    $display("FAIL score_out2 got %h expected %h", score2, e_sc2);
                end
`endif
                exp_fc2 = exp_fc2 + 16'd1;
            end
        end
    end

    // Result monitor for the four-lane instance
    always @(negedge clock) begin
        if (reset_n && cvalid4 && cready4) begin
            checks++;
            if (q4.size() == 0) begin
                errors++;
                $display("FAIL unexpected_result4 class_out=%0d expected none", class4);
            end else begin
                mr4 = q4.pop_front();
                e_idx4 = mr4.idx[3:0];
                e_sc4  = mr4.score[15:0];
                if (class4 !== e_idx4) begin
                    errors++;
                    $display("FAIL class_out4 got %0d expected %0d", class4, e_idx4);
                end
`ifdef ARGMAX_SCORE_EN
                checks++;
                if (score4 !== e_sc4) begin
                    errors++;
                    $display("FAIL score_out4 got %h expected %h", score4, e_sc4);
                end
`endif
            end
        end
    end

    function automatic res_t model();
        res_t r;
        r.idx = 0;
        for (int i = 1; i < 10; i++) begin
            if (sc[i] > sc[r.idx]) r.idx = i;
        end
        r.score = sc[r.idx];
        return r;
    endfunction

    // Drive nb beats of the current score vector; gap bubbles between beats
    task automatic send_frame(input int sel, input int nb, input int gap);
        int nf;
        int n;
        int idx;
        logic [63:0] pk;
        nf = (sel != 0) ? 4 : 2;
        if (nb == ((10 + nf - 1) / nf)) begin
            if (sel != 0) q4.push_back(model());
            else          q2.push_back(model());
        end
        for (int b = 0; b < nb; b++) begin
            @(negedge clock);
            pk = '0;
            for (int i = 0; i < nf; i++) begin
                idx = b * nf + i;
                pk[i*16 +: 16] = (idx < 10) ? sc[idx][15:0] : 16'h7FFF;
            end
            if (sel != 0) begin valid4 = 1'b1; data4 = pk; end
            else          begin valid2 = 1'b1; data2 = pk[31:0]; end
            n = 0;
            while (((sel != 0) ? ready4 : ready2) !== 1'b1 && n < 50) begin
                @(negedge clock);
                n++;
            end
            if (n == 50) begin
                checks++;
                errors++;
                $display("FAIL ready_timeout sel=%0d beat=%0d", sel, b);
            end
            @(posedge clock);
            #1;
            valid2 = 1'b0;
            valid4 = 1'b0;
            repeat (gap) @(negedge clock);
        end
    endtask

    // Wait for the queued result to be consumed, then check frame_count
    task automatic finish_frame(input int sel);
        int n;
        n = 0;
        while (((sel != 0) ? q4.size() : q2.size()) != 0 && n < 50) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (n == 50) begin
            errors++;
            $display("FAIL result_timeout sel=%0d", sel);
        end
        @(negedge clock);
        if (sel == 0) begin
            checks++;
            if (fc2 !== exp_fc2 || ready2 !== 1'b1) begin
                errors++;
                $display("FAIL frame_count2 got %h ready=%b expected %h ready=1", fc2, ready2, exp_fc2);
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        valid2 = 1'b0; valid4 = 1'b0; data2 = '0; data4 = '0;
        cready2 = 1'b1; cready4 = 1'b1;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        checks++;
        if (ready2 !== 1'b1 || cvalid2 !== 1'b0 || class2 !== 4'd0 || fc2 !== 16'd0) begin
            errors++;
            $display("FAIL reset_state ready=%b valid=%b class=%0d fc=%h expected 1 0 0 0000",
                     ready2, cvalid2, class2, fc2);
        end
`ifdef ARGMAX_SCORE_EN
        checks++;
        if (score2 !== 16'd0) begin
            errors++;
            $display("FAIL reset_score got %h expected 0000", score2);
        end
`endif
    endtask

    task automatic test_basic();
        sc = '{1, 5, 3, 9, 2, 0, -4, 7, 8, 6};
        send_frame(0, 5, 0);
        @(negedge clock);
        checks++;
        if (cvalid2 !== 1'b1 || ready2 !== 1'b0) begin
            errors++;
            $display("FAIL latency class_valid=%b ready=%b expected 1 0", cvalid2, ready2);
        end
        finish_frame(0);
    endtask

    task automatic test_ties_signed();
        sc = '{4, 4, 4, 4, 4, 4, 4, 4, 4, 4};
        send_frame(0, 5, 0);
        finish_frame(0);
        sc = '{1, 0, 7, 3, 2, 5, -1, 6, 7, 4};
        send_frame(0, 5, 1);
        finish_frame(0);
        sc = '{-5, -3, -8, -2, -9, -7, -4, -6, -3, -1};
        send_frame(0, 5, 2);
        finish_frame(0);
        sc = '{8, 8, 0, -1, 3, 8, 8, 2, 1, 0};
        send_frame(0, 5, 0);
        finish_frame(0);
    endtask

    task automatic test_partial_beat();
        sc = '{1, 5, 3, 9, 2, 0, -4, 7, 8, 6};
        send_frame(1, 3, 0);
        @(negedge clock);
        checks++;
        if (cvalid4 !== 1'b1) begin
            errors++;
            $display("FAIL beats4 class_valid=%b expected 1 after 3 beats", cvalid4);
        end
        finish_frame(1);
        sc = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 20};
        send_frame(1, 3, 1);
        finish_frame(1);
    endtask

    task automatic test_backpressure();
        logic [3:0] held;
        @(posedge clock);
        #1 cready2 = 1'b0;
        sc = '{3, 1, 4, 1, 5, 9, 2, 6, 5, 3};
        send_frame(0, 5, 0);
        @(negedge clock);
        held = class2;
        valid2 = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            checks++;
            if (cvalid2 !== 1'b1 || ready2 !== 1'b0 || class2 !== held) begin
                errors++;
                $display("FAIL hold cycle=%0d valid=%b ready=%b class=%0d expected 1 0 %0d",
                         c, cvalid2, ready2, class2, held);
            end
        end
        valid2 = 1'b0;
        @(posedge clock);
        #1 cready2 = 1'b1;
        @(negedge clock);
        @(negedge clock);
        checks++;
        if (fc2 !== exp_fc2 || ready2 !== 1'b1) begin
            errors++;
            $display("FAIL release fc=%h ready=%b expected %h 1", fc2, ready2, exp_fc2);
        end
        sc = '{-2, 0, 11, 3, 2, 5, 1, 6, 7, 4};
        send_frame(0, 5, 0);
        finish_frame(0);
    endtask

    task automatic test_frame_wrap();
        @(negedge clock);
        dut.frame_count_q = 16'hFFFF;
        exp_fc2 = 16'hFFFF;
        sc = '{9, 1, 2, 3, 4, 5, 6, 7, 8, 0};
        send_frame(0, 5, 0);
        finish_frame(0);
        checks++;
        if (fc2 !== 16'h0000) begin
            errors++;
            $display("FAIL wrap fc=%h expected 0000", fc2);
        end
    endtask

    task automatic test_reset_mid_frame();
        sc = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
        send_frame(0, 3, 0);
        reset_n = 1'b0;
        exp_fc2 = 16'd0;
        #1;
        checks++;
        if (ready2 !== 1'b1 || cvalid2 !== 1'b0 || fc2 !== 16'd0) begin
            errors++;
            $display("FAIL async_reset ready=%b valid=%b fc=%h expected 1 0 0000", ready2, cvalid2, fc2);
        end
        @(negedge clock);
        reset_n = 1'b1;
        repeat (3) @(negedge clock);
        checks++;
        if (cvalid2 !== 1'b0 || fc2 !== 16'd0) begin
            errors++;
            $display("FAIL no_result valid=%b fc=%h expected 0 0000", cvalid2, fc2);
        end
        sc = '{0, 2, 14, 3, 1, 5, -7, 6, 13, 4};
        send_frame(0, 5, 0);
        finish_frame(0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ties_signed();
        test_partial_beat();
        test_backpressure();
        test_frame_wrap();
        test_reset_mid_frame();
        checks++;
        if (q2.size() != 0 || q4.size() != 0) begin
            errors++;
            $display("FAIL leftover_results q2=%0d q4=%0d expected 0 0", q2.size(), q4.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/argmax_classifier.md
ARGMAX_CLASSIFIER -- requirements
Module: argmax_classifier

Interface
REQ-001 SHALL have parameter VECTOR_LENGTH, default 10, number of class scores per frame (>=2).
REQ-002 SHALL have parameter NUM_FEATURES, default 2, lanes per input beat; SHALL match the upstream dense stage.
REQ-003 SHALL have port clock  input  1  rising-edge clock.
REQ-004 SHALL have port reset_n  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port features_in  feature_if (consumer side)  valid in, ready out, features[NUM_FEATURES] of mnist_pkg::feature_type in  score stream.
REQ-006 SHALL have port class_out  output  $clog2(VECTOR_LENGTH)  predicted class index.
REQ-007 SHALL have port class_valid  output  1  class_out (and score_out) valid.
REQ-008 SHALL have port class_ready  input  1  downstream accepts result.
REQ-009 SHALL have port frame_count  output  16  number of results accepted downstream.
REQ-010 SHALL have port score_out  output  feature_type width  winning score; present only under ARGMAX_SCORE_EN.

Function
REQ-011 SHALL implement two states: S_RECV (features_in.ready=1, class_valid=0) and S_RESULT (features_in.ready=0, class_valid=1).
REQ-012 SHALL accept an input beat only when features_in.valid & features_in.ready.
REQ-013 SHALL expect BEATS = ceil(VECTOR_LENGTH/NUM_FEATURES) beats per frame, tracked by a beat counter; lane i of beat b carries index b*NUM_FEATURES+i.
REQ-014 SHALL ignore lanes whose index >= VECTOR_LENGTH (partial final beat).
REQ-015 SHALL compare scores as signed two's-complement feature_type values.
REQ-016 SHALL reduce each beat's valid lanes combinationally to a beat maximum and compare it to the running maximum in the same cycle.
REQ-017 SHALL load the running max/index unconditionally from the first beat of a frame.
REQ-018 SHALL break ties toward the lowest index (replace only on strictly greater), across lanes and across beats.
REQ-019 SHALL transition S_RECV->S_RESULT on acceptance of beat BEATS-1; class_valid SHALL assert the following cycle (1-cycle latency).
REQ-020 SHALL hold class_out/score_out stable while class_valid=1 and class_ready=0.
REQ-021 SHALL transition S_RESULT->S_RECV on class_valid & class_ready, clear the beat counter, and increment frame_count in that cycle.
REQ-022 SHALL not accept input in the cycle a result is consumed (ready is low throughout S_RESULT); first beat of next frame earliest one cycle later.
REQ-023 SHALL wrap frame_count from 16'hFFFF to 0 without flagging.
REQ-024 SHALL not alter running state on cycles where features_in.valid is low in S_RECV (bubbles allowed anywhere in a frame).

Reset
REQ-025 SHALL, on reset_n low, asynchronously enter S_RECV, clear beat counter, running max/index, class_out, score_out and frame_count to 0; class_valid=0, features_in.ready=1 after release.
REQ-026 SHALL discard any partially received frame or pending result on reset mid-operation; first beat after release starts a new frame.

Configuration
REQ-027 SHALL, with ARGMAX_SCORE_EN defined, expose score_out equal to the winning score, registered with class_out.
REQ-028 SHALL, without ARGMAX_SCORE_EN, omit score_out port and its register; all other behaviour identical.

Verification
REQ-029 Scores 0..9 = {1,5,3,9,2,0,-4,7,8,6}, NUM_FEATURES=2, back-to-back beats -> class_out=3, class_valid 1 cycle after 5th beat, score_out=9 (if enabled).
REQ-030 Scores all equal 4 -> class_out=0; scores {...} with max 7 at indices 2 and 8 -> class_out=2.
REQ-031 All scores negative, max -1 at index 9 -> class_out=9 (signed compare).
REQ-032 VECTOR_LENGTH=10, NUM_FEATURES=4, lanes 2-3 of beat 2 driven to 0x7FFF -> ignored; 3 beats per frame, correct class.
REQ-033 class_ready held low 5 cycles -> class_out stable, ready=0, no beats accepted; then ready high -> frame_count +1, next frame accepted from next cycle; frame_count preset path 0xFFFF -> 0.
REQ-034 reset_n pulsed after 3 of 5 beats -> no result; next full frame classified correctly, frame_count=0 before its acceptance.
